// File: rtl/logic_unit_pipe_if.sv
// Handshake and data bundle for logic_unit_pipe.
// master: producer/consumer side (drives operands, accepts results).
// slave : the pipeline itself.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PCW   = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             zero;
  logic [PCW-1:0]   popcnt;

  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, C, zero, popcnt
  );

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, C, zero, popcnt
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with valid/ready flow control.
// S1 registers op/A/B, S2 registers the result C plus its zero flag and
// popcount. Latency 2, throughput one beat per cycle.
// Optional feature: define LOGIC_UNIT_POPCNT_EN to compute popcnt in S2;
// otherwise popcnt keeps its width and is tied to zero.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PCW   = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  logic_unit_pipe_if.slave  bus
);

  // Stage 1: captured operands
  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  // Stage 2: registered result
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             zero_q, zero_d;

  // Combinational result computed from S1
  logic [WIDTH-1:0] res_c;
  logic             res_zero;

  // Handshake
  logic             s2_load;
  logic             in_ready;
  logic             accept;

  // S2 takes the S1 beat whenever its current beat is absent or being consumed;
  // S1 accepts when empty or when it is emptying into S2 this cycle.
  always_comb begin
    s2_load  = s1_valid_q & (~s2_valid_q | bus.out_ready);
    in_ready = ~s1_valid_q | s2_load;
    accept   = bus.in_valid & in_ready;
  end

  // S1 next state: load on acceptance, empty when drained with nothing new.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = bus.op;
      s1_a_d     = bus.A;
      s1_b_d     = bus.B;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // Operation decode on the S1 operands.
  always_comb begin
    res_c = '0;
    unique case (s1_op_q)
      3'b000: res_c = s1_a_q & s1_b_q;
      3'b001: res_c = s1_a_q | s1_b_q;
      3'b010: res_c = s1_a_q ^ s1_b_q;
      3'b011: res_c = ~(s1_a_q & s1_b_q);
      3'b100: res_c = ~(s1_a_q | s1_b_q);
      3'b101: res_c = ~(s1_a_q ^ s1_b_q);
      3'b110: res_c = s1_a_q & ~s1_b_q;
      3'b111: res_c = s1_a_q;
      default: res_c = '0;
    endcase
    res_zero = ~|res_c;
  end

  // S2 next state: flags derive from res_c, the same value loaded into C.
  always_comb begin
    s2_valid_d = s2_valid_q;
    c_d        = c_q;
    zero_d     = zero_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      c_d        = res_c;
      zero_d     = res_zero;
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers with synchronous reset; in-flight beats are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      c_q        <= '0;
      zero_q     <= 1'b1;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      c_q        <= c_d;
      zero_q     <= zero_d;
    end
  end

`ifdef LOGIC_UNIT_POPCNT_EN
  logic [PCW-1:0] res_pop;
  logic [PCW-1:0] popcnt_q, popcnt_d;

  // Count ones of the S1 result so it lands in S2 together with C.
  always_comb begin
    res_pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      res_pop = res_pop + PCW'(res_c[i]);
    end
    popcnt_d = s2_load ? res_pop : popcnt_q;
  end

  // Popcount register shares the S2 load/reset behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      popcnt_q <= '0;
    end else begin
      popcnt_q <= popcnt_d;
    end
  end

  assign bus.popcnt = popcnt_q;
`else
  assign bus.popcnt = '0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.C         = c_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed cases plus randomized
// traffic scored against a queue-based reference model.
module tb_logic_unit_pipe;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  logic_unit_pipe_if #(.WIDTH(32)) bus ();
  logic_unit_pipe_if #(.WIDTH(8))  bus8 ();

  logic_unit_pipe #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_c(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction

  function automatic logic [63:0] exp_pop(input logic [63:0] c);
`ifdef LOGIC_UNIT_POPCNT_EN
    return 64'($countones(c));
`else
    return 64'(c & 64'd0);
`endif
  endfunction

  // Reference model: results of accepted beats, in order.
  logic [31:0] model_q[$];
  logic        hold_pend;
  logic [31:0] hold_c;

  // Scoreboard sampled mid-cycle; values seen here decide the next rising edge.
  always @(negedge clk) begin
    logic [31:0] e;
    int          occ;
    if (rst) begin
      model_q.delete();
      hold_pend = 1'b0;
    end else begin
      occ = model_q.size();
      // Two beats in flight means both stages are full.
      check("in_ready", 64'(bus.in_ready), 64'((occ < 2) || bus.out_ready));
      if (hold_pend) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_c", 64'(bus.C), 64'(hold_c));
      end
      if (bus.out_valid && bus.out_ready) begin
        check("out_has_ref", 64'(occ != 0), 64'd1);
        if (occ != 0) begin
          e = model_q.pop_front();
          check("c", 64'(bus.C), 64'(e));
          check("zero", 64'(bus.zero), 64'(e == 32'd0));
          check("popcnt", 64'(bus.popcnt), exp_pop(64'(e)));
        end
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_c    = bus.C;
      if (bus.in_valid && bus.in_ready) model_q.push_back(ref_c(bus.op, bus.A, bus.B));
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int g;
    g = 0;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.A        = a;
    bus.B        = b;
    @(negedge clk);
    while (!bus.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("send_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [31:0] exp);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus.out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_c"}, 64'(bus.C), 64'(exp));
    check({tag, "_zero"}, 64'(bus.zero), 64'(exp == 32'd0));
    check({tag, "_pop"}, 64'(bus.popcnt), exp_pop(64'(exp)));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  bb_op[4];
    logic [31:0] bb_a[4];
    logic [31:0] bb_b[4];
    logic [31:0] bb_r[4];

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0; bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.op = '0; bus8.A = '0; bus8.B = '0; bus8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_c", 64'(bus.C), 64'd0);
    check("rst_zero", 64'(bus.zero), 64'd1);
    check("rst_pop", 64'(bus.popcnt), 64'd0);
    check("rst8_in_ready", 64'(bus8.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Latency 2: AND with zero operand
    send(3'b000, 32'd1234, 32'd0);
    @(negedge clk);
    check("lat_early", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid", 64'(bus.out_valid), 64'd1);
    check("lat_c", 64'(bus.C), 64'd0);
    check("lat_zero", 64'(bus.zero), 64'd1);
    check("lat_pop", 64'(bus.popcnt), 64'd0);
    @(posedge clk);
    #1;

    send(3'b000, 32'd1234, 32'd1234);
    wait_out("and_same", 32'd1234);
    check("and_same_pop5", 64'(bus.popcnt), exp_pop(64'd1234));
    send(3'b000, 32'd99999, 32'd9999);
    wait_out("and_mix", 32'h60F);
    send(3'b010, 32'd0, 32'd9999);
    wait_out("xor_zero", 32'd9999);

    // All eight op codes on a fixed pattern
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 32'hFFFF0000, 32'hFF00FF00);
      wait_out($sformatf("op%0d", i), ref_c(3'(i), 32'hFFFF0000, 32'hFF00FF00));
    end

    // Back-pressure: four beats with the consumer stalled
    bb_op = '{3'd0, 3'd1, 3'd2, 3'd6};
    bb_a  = '{32'h0F0F1234, 32'h00F0AA00, 32'hDEADBEEF, 32'hCAFEF00D};
    bb_b  = '{32'h00FF0F0F, 32'h0F000055, 32'h12345678, 32'h0000FFFF};
    for (int i = 0; i < 4; i++) bb_r[i] = ref_c(bb_op[i], bb_a[i], bb_b[i]);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.op = bb_op[0]; bus.A = bb_a[0]; bus.B = bb_b[0];
    @(negedge clk);
    check("bb_rdy0", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.op = bb_op[1]; bus.A = bb_a[1]; bus.B = bb_b[1];
    @(negedge clk);
    check("bb_rdy1", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.op = bb_op[2]; bus.A = bb_a[2]; bus.B = bb_b[2];
    repeat (5) begin
      @(negedge clk);
      check("bb_stall_rdy", 64'(bus.in_ready), 64'd0);
      check("bb_stall_v", 64'(bus.out_valid), 64'd1);
      check("bb_stall_c", 64'(bus.C), 64'(bb_r[0]));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    fork
      begin
        send(bb_op[2], bb_a[2], bb_b[2]);
        send(bb_op[3], bb_a[3], bb_b[3]);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check($sformatf("bb_out%0d_v", i), 64'(bus.out_valid), 64'd1);
          check($sformatf("bb_out%0d_c", i), 64'(bus.C), 64'(bb_r[i]));
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Reset with two beats in flight
    bus.out_ready = 1'b0;
    send(3'b001, 32'h11110000, 32'h00002222);
    send(3'b111, 32'h5A5A5A5A, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_v", 64'(bus.out_valid), 64'd0);
    check("mid_rst_c", 64'(bus.C), 64'd0);
    check("mid_rst_zero", 64'(bus.zero), 64'd1);
    check("mid_rst_rdy", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("mid_rst_ghost", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Narrow instance: AND at WIDTH=8
    bus8.op = 3'b000; bus8.A = 8'hF0; bus8.B = 8'h3C; bus8.in_valid = 1'b1;
    @(negedge clk);
    check("w8_rdy", 64'(bus8.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    check("w8_early", 64'(bus8.out_valid), 64'd0);
    @(negedge clk);
    check("w8_valid", 64'(bus8.out_valid), 64'd1);
    check("w8_c", 64'(bus8.C), 64'h30);
    check("w8_zero", 64'(bus8.zero), 64'd0);
    check("w8_pop", 64'(bus8.popcnt), exp_pop(64'h30));
    @(posedge clk);
    #1;

    // Randomized traffic with occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.op        = 3'($urandom_range(0, 7));
      bus.A         = $urandom;
      bus.B         = $urandom;
      if ($urandom_range(0, 7) == 0) bus.A = '0;
      if ($urandom_range(0, 7) == 0) bus.B = bus.A;
      bus.out_ready = ($urandom_range(0, 9) < 6);
      rst           = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    check("drain_empty", 64'(model_q.size()), 64'd0);
    check("drain_out_valid", 64'(bus.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
